// File: rtl/sound_latch_bridge.sv
// Sound command/reply latch pair between the 68k main CPU and the Z80 sound CPU.
// Command byte 68k -> Z80 raises the Z80 INT line; reply byte Z80 -> 68k.
// Every bus access is detected on the rising edge of its qualified strobe.
module sound_latch_bridge #(
   parameter bit IRQ_ACK_CLEAR = 1'b1,
   parameter int HOLD_CYCLES   = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        m68k_latch_cs,
   input  logic        m68k_uds_n,
   input  logic [15:0] m68k_dout,
   input  logic        z80_latch_read_cs,
   input  logic        z80_latch_cs,
   input  logic        z80_rd_n,
   input  logic        z80_wr_n,
   input  logic [7:0]  z80_dout,
   input  logic        M1_n,
   input  logic        IORQ_n,
   output logic [7:0]  sound_latch,
   output logic [7:0]  sound_latch2,
   output logic        z80_irq_n,
   output logic        cmd_full,
   output logic        reply_full,
   output logic        cmd_overrun
);

   localparam int HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
   localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES);

   // Low byte of the 68k bus is not part of the command.
   logic unused_dout;
   assign unused_dout = ^m68k_dout[7:0];

   logic wr68_s, rd80_s, wr80_s, rdrep_s, iack_s;
   logic wr68_q, rd80_q, wr80_q, rdrep_q, iack_q;
   logic arm_q;
   logic wr68_evt, rd80_evt, wr80_evt, rdrep_evt, iack_evt, rel_evt;

   logic [7:0]    sl_q, sl_d, sl2_q, sl2_d;
   logic          irq_n_q, irq_n_d, cf_q, cf_d, rf_q, rf_d, ov_q, ov_d;
   logic          pend_q, pend_d;
   logic [HW-1:0] hold_q, hold_d, hold_dec;

   assign wr68_s  = m68k_latch_cs & ~m68k_uds_n;
   assign rd80_s  = z80_latch_cs & ~z80_rd_n;
   assign wr80_s  = z80_latch_cs & ~z80_wr_n;
   assign rdrep_s = z80_latch_read_cs;
   assign iack_s  = ~M1_n & ~IORQ_n;

   // arm_q stays low for the first edge after reset so a strobe that was
   // already high while in reset is absorbed into the history registers.
   assign wr68_evt  = arm_q & wr68_s  & ~wr68_q;
   assign rd80_evt  = arm_q & rd80_s  & ~rd80_q;
   assign wr80_evt  = arm_q & wr80_s  & ~wr80_q;
   assign rdrep_evt = arm_q & rdrep_s & ~rdrep_q;
   assign iack_evt  = arm_q & iack_s  & ~iack_q;
   assign rel_evt   = IRQ_ACK_CLEAR ? iack_evt : rd80_evt;

   // Next-state for latches, flags, IRQ line and its minimum-low hold timer.
   always_comb begin
      sl_d     = sl_q;
      sl2_d    = sl2_q;
      irq_n_d  = irq_n_q;
      cf_d     = cf_q;
      rf_d     = rf_q;
      ov_d     = ov_q;
      pend_d   = pend_q;
      hold_dec = (hold_q != '0) ? hold_q - HW'(1) : '0;
      hold_d   = hold_dec;

      if (wr68_evt) begin
         // A new command always wins over a same-cycle read or release.
         sl_d    = m68k_dout[15:8];
         cf_d    = 1'b1;
         irq_n_d = 1'b0;
         hold_d  = HOLD_LOAD;
         pend_d  = 1'b0;
         if (cf_q && !rd80_evt) ov_d = 1'b1;
      end else begin
         if (rd80_evt) cf_d = 1'b0;
         if ((rel_evt || pend_q) && (hold_dec == '0)) begin
            irq_n_d = 1'b1;
            pend_d  = 1'b0;
         end else if (rel_evt) begin
            pend_d = 1'b1;
         end
      end

      if (wr80_evt) begin
         sl2_d = z80_dout;
         rf_d  = 1'b1;
      end else if (rdrep_evt) begin
         rf_d = 1'b0;
      end
   end

   // State registers, edge-detect history included, all cleared by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr68_q  <= 1'b0;
         rd80_q  <= 1'b0;
         wr80_q  <= 1'b0;
         rdrep_q <= 1'b0;
         iack_q  <= 1'b0;
         arm_q   <= 1'b0;
         sl_q    <= 8'h00;
         sl2_q   <= 8'h00;
         irq_n_q <= 1'b1;
         cf_q    <= 1'b0;
         rf_q    <= 1'b0;
         ov_q    <= 1'b0;
         pend_q  <= 1'b0;
         hold_q  <= '0;
      end else begin
         wr68_q  <= wr68_s;
         rd80_q  <= rd80_s;
         wr80_q  <= wr80_s;
         rdrep_q <= rdrep_s;
         iack_q  <= iack_s;
         arm_q   <= 1'b1;
         sl_q    <= sl_d;
         sl2_q   <= sl2_d;
         irq_n_q <= irq_n_d;
         cf_q    <= cf_d;
         rf_q    <= rf_d;
         ov_q    <= ov_d;
         pend_q  <= pend_d;
         hold_q  <= hold_d;
      end
   end

   assign sound_latch  = sl_q;
   assign sound_latch2 = sl2_q;
   assign z80_irq_n    = irq_n_q;
   assign cmd_full     = cf_q;
   assign reply_full   = rf_q;
   assign cmd_overrun  = ov_q;

endmodule

// File: tb/tb_sound_latch_bridge.sv
// Bench for sound_latch_bridge: three parameterisations driven in parallel,
// checked against fixed vectors, hand sequences and an event-level model.
module tb_sound_latch_bridge;

   logic        clk = 1'b0;
   logic        reset;
   logic        cs, uds_n, rdcs, zcs, rd_n, wr_n, m1_n, iorq_n;
   logic [15:0] dout;
   logic [7:0]  zdout;

   logic [7:0] sl_w[3], sl2_w[3];
   logic       irq_w[3], cf_w[3], rf_w[3], ov_w[3];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   sound_latch_bridge #(.IRQ_ACK_CLEAR(1'b1), .HOLD_CYCLES(0)) u0 (
      .clk(clk), .reset(reset), .m68k_latch_cs(cs), .m68k_uds_n(uds_n), .m68k_dout(dout),
      .z80_latch_read_cs(rdcs), .z80_latch_cs(zcs), .z80_rd_n(rd_n), .z80_wr_n(wr_n),
      .z80_dout(zdout), .M1_n(m1_n), .IORQ_n(iorq_n), .sound_latch(sl_w[0]),
      .sound_latch2(sl2_w[0]), .z80_irq_n(irq_w[0]), .cmd_full(cf_w[0]),
      .reply_full(rf_w[0]), .cmd_overrun(ov_w[0]));

   sound_latch_bridge #(.IRQ_ACK_CLEAR(1'b0), .HOLD_CYCLES(3)) u1 (
      .clk(clk), .reset(reset), .m68k_latch_cs(cs), .m68k_uds_n(uds_n), .m68k_dout(dout),
      .z80_latch_read_cs(rdcs), .z80_latch_cs(zcs), .z80_rd_n(rd_n), .z80_wr_n(wr_n),
      .z80_dout(zdout), .M1_n(m1_n), .IORQ_n(iorq_n), .sound_latch(sl_w[1]),
      .sound_latch2(sl2_w[1]), .z80_irq_n(irq_w[1]), .cmd_full(cf_w[1]),
      .reply_full(rf_w[1]), .cmd_overrun(ov_w[1]));

   sound_latch_bridge #(.IRQ_ACK_CLEAR(1'b1), .HOLD_CYCLES(3)) u2 (
      .clk(clk), .reset(reset), .m68k_latch_cs(cs), .m68k_uds_n(uds_n), .m68k_dout(dout),
      .z80_latch_read_cs(rdcs), .z80_latch_cs(zcs), .z80_rd_n(rd_n), .z80_wr_n(wr_n),
      .z80_dout(zdout), .M1_n(m1_n), .IORQ_n(iorq_n), .sound_latch(sl_w[2]),
      .sound_latch2(sl2_w[2]), .z80_irq_n(irq_w[2]), .cmd_full(cf_w[2]),
      .reply_full(rf_w[2]), .cmd_overrun(ov_w[2]));

   // ---------------- reference model (event level) ----------------
   int p_ack[3]  = '{1, 0, 1};
   int p_hold[3] = '{0, 3, 3};

   typedef struct {
      logic [7:0] sl, sl2;
      logic irq_n, cf, rf, ov;
      int   lw, lr, lzw, lrr, lack;   // last sampled strobe level, -1 = none since reset
      int   age;                      // edges since IRQ was last asserted
      bit   req;                      // release asked for, waiting out the hold time
   } mst_t;
   mst_t m[3];

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m[i].sl = 8'h00; m[i].sl2 = 8'h00; m[i].irq_n = 1'b1;
         m[i].cf = 1'b0; m[i].rf = 1'b0; m[i].ov = 1'b0;
         m[i].lw = -1; m[i].lr = -1; m[i].lzw = -1; m[i].lrr = -1; m[i].lack = -1;
         m[i].age = 1000; m[i].req = 1'b0;
      end
   endtask

   function automatic bit rose(input int last, input logic cur);
      return (last == 0) && (cur == 1'b1);
   endfunction

   task automatic model_step();
      logic w, r, zw, rr, ak;
      bit ew, er, ezw, err, eak, rel;
      if (reset) begin
         model_reset();
         return;
      end
      w = cs & ~uds_n; r = zcs & ~rd_n; zw = zcs & ~wr_n; rr = rdcs; ak = ~m1_n & ~iorq_n;
      for (int i = 0; i < 3; i++) begin
         ew = rose(m[i].lw, w); er = rose(m[i].lr, r); ezw = rose(m[i].lzw, zw);
         err = rose(m[i].lrr, rr); eak = rose(m[i].lack, ak);
         m[i].lw = int'(w); m[i].lr = int'(r); m[i].lzw = int'(zw);
         m[i].lrr = int'(rr); m[i].lack = int'(ak);
         if (m[i].age < 1000) m[i].age++;
         if (ew) begin
            if (m[i].cf && !er) m[i].ov = 1'b1;
            m[i].sl = dout[15:8]; m[i].cf = 1'b1; m[i].irq_n = 1'b0;
            m[i].age = 0; m[i].req = 1'b0;
         end else begin
            if (er) m[i].cf = 1'b0;
            rel = (p_ack[i] == 1) ? eak : er;
            if (rel) m[i].req = 1'b1;
            if (m[i].req && m[i].age >= p_hold[i]) begin
               m[i].irq_n = 1'b1; m[i].req = 1'b0;
            end
         end
         if (ezw) begin
            m[i].sl2 = zdout; m[i].rf = 1'b1;
         end else if (err) begin
            m[i].rf = 1'b0;
         end
      end
   endtask

   // ---------------- checking helpers ----------------
   task automatic chk(input string nm, input int inst, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s inst%0d t=%0t got=%h want=%h", nm, inst, $time, act, exp);
      end
   endtask

   task automatic check_model();
      for (int i = 0; i < 3; i++) begin
         chk("sound_latch",  i, sl_w[i],         m[i].sl);
         chk("sound_latch2", i, sl2_w[i],        m[i].sl2);
         chk("z80_irq_n",    i, {7'd0, irq_w[i]}, {7'd0, m[i].irq_n});
         chk("cmd_full",     i, {7'd0, cf_w[i]},  {7'd0, m[i].cf});
         chk("reply_full",   i, {7'd0, rf_w[i]},  {7'd0, m[i].rf});
         chk("cmd_overrun",  i, {7'd0, ov_w[i]},  {7'd0, m[i].ov});
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check_model();
   endtask

   // ctl = {cs, uds_n, rdcs, zcs, rd_n, wr_n, m1_n, iorq_n}
   localparam logic [7:0] IDLE  = 8'b0100_1111;
   localparam logic [7:0] W68   = 8'b1000_1111;
   localparam logic [7:0] WUDS  = 8'b1100_1111;
   localparam logic [7:0] IACK  = 8'b0100_1100;
   localparam logic [7:0] ZRD   = 8'b0101_0111;
   localparam logic [7:0] ZWR   = 8'b0101_1011;
   localparam logic [7:0] RREP  = 8'b0110_1111;
   localparam logic [7:0] ZWRR  = 8'b0111_1011;
   localparam logic [7:0] ZRACK = 8'b0101_0100;
   localparam logic [7:0] ALLHI = 8'b1011_0100;

   task automatic drive(input logic [7:0] ctl, input logic [15:0] d, input logic [7:0] zd);
      {cs, uds_n, rdcs, zcs, rd_n, wr_n, m1_n, iorq_n} = ctl;
      dout  = d;
      zdout = zd;
   endtask

   typedef struct {
      logic [7:0]  ctl;
      logic [15:0] d;
      logic [7:0]  zd;
      logic [7:0]  e_sl, e_sl2;
      logic [3:0]  e_fl;   // {irq_n, cmd_full, reply_full, cmd_overrun} of instance 0
   } vec_t;

   function automatic vec_t mkv(input logic [7:0] c, input logic [15:0] d, input logic [7:0] zd,
                                input logic [7:0] s1, input logic [7:0] s2, input logic [3:0] f);
      vec_t v;
      v.ctl = c; v.d = d; v.zd = zd; v.e_sl = s1; v.e_sl2 = s2; v.e_fl = f;
      return v;
   endfunction

   vec_t vt[22];

   initial begin
      vt[0]  = mkv(W68,  16'h5A00, 8'h00, 8'h5A, 8'h00, 4'b0100);
      vt[1]  = mkv(W68,  16'h5A00, 8'h00, 8'h5A, 8'h00, 4'b0100);
      vt[2]  = mkv(W68,  16'h5A00, 8'h00, 8'h5A, 8'h00, 4'b0100);
      vt[3]  = mkv(W68,  16'h5A00, 8'h00, 8'h5A, 8'h00, 4'b0100);
      vt[4]  = mkv(IDLE, 16'h0000, 8'h00, 8'h5A, 8'h00, 4'b0100);
      vt[5]  = mkv(IACK, 16'h0000, 8'h00, 8'h5A, 8'h00, 4'b1100);
      vt[6]  = mkv(IACK, 16'h0000, 8'h00, 8'h5A, 8'h00, 4'b1100);
      vt[7]  = mkv(IDLE, 16'h0000, 8'h00, 8'h5A, 8'h00, 4'b1100);
      vt[8]  = mkv(ZRD,  16'h0000, 8'h00, 8'h5A, 8'h00, 4'b1000);
      vt[9]  = mkv(IDLE, 16'h0000, 8'h00, 8'h5A, 8'h00, 4'b1000);
      vt[10] = mkv(W68,  16'h1100, 8'h00, 8'h11, 8'h00, 4'b0100);
      vt[11] = mkv(IDLE, 16'h0000, 8'h00, 8'h11, 8'h00, 4'b0100);
      vt[12] = mkv(W68,  16'h2200, 8'h00, 8'h22, 8'h00, 4'b0101);
      vt[13] = mkv(IDLE, 16'h0000, 8'h00, 8'h22, 8'h00, 4'b0101);
      vt[14] = mkv(WUDS, 16'h3300, 8'h00, 8'h22, 8'h00, 4'b0101);
      vt[15] = mkv(IDLE, 16'h0000, 8'h00, 8'h22, 8'h00, 4'b0101);
      vt[16] = mkv(ZWR,  16'h0000, 8'hA5, 8'h22, 8'hA5, 4'b0111);
      vt[17] = mkv(IDLE, 16'h0000, 8'h00, 8'h22, 8'hA5, 4'b0111);
      vt[18] = mkv(RREP, 16'h0000, 8'h00, 8'h22, 8'hA5, 4'b0101);
      vt[19] = mkv(IDLE, 16'h0000, 8'h00, 8'h22, 8'hA5, 4'b0101);
      vt[20] = mkv(ZWRR, 16'h0000, 8'h3C, 8'h22, 8'h3C, 4'b0111);
      vt[21] = mkv(IDLE, 16'h0000, 8'h00, 8'h22, 8'h3C, 4'b0111);

      // reset state
      drive(IDLE, 16'h0, 8'h0);
      reset = 1'b1;
      model_reset();
      tick();
      tick();
      chk("rst_sl", 0, sl_w[0], 8'h00);
      chk("rst_irq_n", 0, {7'd0, irq_w[0]}, 8'h01);
      chk("rst_flags", 0, {5'd0, cf_w[0], rf_w[0], ov_w[0]}, 8'h00);
      reset = 1'b0;
      tick();

      // fixed vectors against instance 0, model against all
      for (int k = 0; k < 22; k++) begin
         drive(vt[k].ctl, vt[k].d, vt[k].zd);
         tick();
         chk("vec_sl",  k, sl_w[0],  vt[k].e_sl);
         chk("vec_sl2", k, sl2_w[0], vt[k].e_sl2);
         chk("vec_flags", k, {4'd0, irq_w[0], cf_w[0], rf_w[0], ov_w[0]}, {4'd0, vt[k].e_fl});
      end

      // hold timing: assert, release requested one clock later
      drive(W68, 16'h7700, 8'h00);
      tick();
      chk("hold_e0_irq", 2, {7'd0, irq_w[2]}, 8'h00);
      drive(ZRACK, 16'h0000, 8'h00);
      tick();
      chk("hold_e1_irq", 0, {7'd0, irq_w[0]}, 8'h01);
      chk("hold_e1_irq", 1, {7'd0, irq_w[1]}, 8'h00);
      chk("hold_e1_irq", 2, {7'd0, irq_w[2]}, 8'h00);
      chk("hold_e1_cf",  1, {7'd0, cf_w[1]},  8'h00);
      drive(IDLE, 16'h0000, 8'h00);
      tick();
      chk("hold_e2_irq", 1, {7'd0, irq_w[1]}, 8'h00);
      chk("hold_e2_irq", 2, {7'd0, irq_w[2]}, 8'h00);
      tick();
      chk("hold_e3_irq", 1, {7'd0, irq_w[1]}, 8'h01);
      chk("hold_e3_irq", 2, {7'd0, irq_w[2]}, 8'h01);
      tick();

      // reset with IRQ low and strobes held high, release with strobes high
      drive(ALLHI, 16'h9900, 8'h00);
      tick();
      chk("pre_rst_irq", 0, {7'd0, irq_w[0]}, 8'h00);
      reset = 1'b1;
      #1;
      model_reset();
      check_model();
      chk("async_rst_ov", 2, {7'd0, ov_w[2]}, 8'h00);
      tick();
      reset = 1'b0;
      tick();
      tick();
      chk("no_evt_sl",  0, sl_w[0], 8'h00);
      chk("no_evt_cf",  0, {7'd0, cf_w[0]},  8'h00);
      chk("no_evt_irq", 2, {7'd0, irq_w[2]}, 8'h01);
      drive(IDLE, 16'h0000, 8'h00);
      tick();

      // randomized traffic against the model
      for (int n = 0; n < 600; n++) begin
         logic [7:0] c;
         c = IDLE;
         if ($urandom_range(0, 3) == 0) c[7] = ~cs;     else c[7] = cs;
         c[6] = ($urandom_range(0, 4) == 0);
         if ($urandom_range(0, 4) == 0) c[5] = ~rdcs;   else c[5] = rdcs;
         if ($urandom_range(0, 3) == 0) c[4] = ~zcs;    else c[4] = zcs;
         c[3] = ($urandom_range(0, 2) != 0);
         c[2] = ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 3) == 0) c[1] = ~m1_n;   else c[1] = m1_n;
         if ($urandom_range(0, 3) == 0) c[0] = ~iorq_n; else c[0] = iorq_n;
         drive(c, 16'($urandom), 8'($urandom));
         reset = ($urandom_range(0, 149) == 0);
         tick();
      end
      reset = 1'b0;
      drive(IDLE, 16'h0000, 8'h00);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
